// File: rtl/regfile_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK controller for the 8-bit datapath:
// fetches 16-bit instructions, drives register-file addresses/strobe and the ALU op select.
//
// state     | meaning
// IDLE      | waiting for start
// FETCH     | instr_addr=PC, wait for instr_valid, latch IR
// DECODE    | register-file read addresses presented
// EXECUTE   | alu_op driven, ALU result and Z captured
// WRITEBACK | register write strobe, PC update
// HALTED    | HALT executed, left only by reset
module regfile_sequencer #(
  parameter int          PC_WIDTH = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  output logic [PC_WIDTH-1:0] instr_addr,
  input  logic [15:0]         instr_data,
  input  logic                instr_valid,
  output logic [2:0]          rf_read_address1,
  output logic [2:0]          rf_read_address2,
  output logic [2:0]          rf_write_address,
  output logic                rf_write_enable,
  output logic [7:0]          rf_write_data,
  output logic [2:0]          alu_op,
  input  logic [7:0]          alu_result,
  input  logic                alu_zero,
  output logic                busy,
  output logic                halted,
  output logic                illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALTED
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc, pc_nxt;
  logic [15:0]         ir;
  logic [7:0]          result_q;
  logic                z_q;
  logic                illegal_q;

  logic [3:0] opcode;
  logic [2:0] rd, rs1, rs2;
  logic [7:0] imm8;
  logic       is_arith, uses_alu, writes_rf, is_undef;
  logic [PC_WIDTH-1:0] jump_target;

  assign opcode      = ir[15:12];
  assign rd          = ir[11:9];
  assign rs1         = ir[8:6];
  assign rs2         = ir[5:3];
  assign imm8        = ir[7:0];
  assign is_arith    = (opcode >= OP_ADD) && (opcode <= OP_XOR);
  assign uses_alu    = (opcode >= OP_ADD) && (opcode <= OP_MOV);
  assign writes_rf   = (opcode >= OP_ADD) && (opcode <= OP_LDI);
  assign is_undef    = (opcode > OP_JZ) && (opcode != OP_HALT);
  assign jump_target = PC_WIDTH'(imm8);

  always_comb begin
    pc_nxt = pc + PC_WIDTH'(1);
    case (opcode)
      OP_JMP:  pc_nxt = jump_target;
      OP_JZ:   if (z_q) pc_nxt = jump_target;
      OP_HALT: pc_nxt = pc;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= PC_WIDTH'(RESET_PC);
      ir        <= '0;
      result_q  <= '0;
      z_q       <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (state == S_FETCH && instr_valid) ir <= instr_data;
      if (state == S_EXECUTE) begin
        result_q <= alu_result;
        if (is_arith) z_q <= alu_zero;
        if (is_undef) illegal_q <= 1'b1;
      end
      if (state == S_WRITEBACK) pc <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = S_FETCH;
      S_FETCH:     if (instr_valid) state_nxt = S_DECODE;
      S_DECODE:    state_nxt = S_EXECUTE;
      S_EXECUTE:   state_nxt = S_WRITEBACK;
      S_WRITEBACK: state_nxt = (opcode == OP_HALT) ? S_HALTED : S_FETCH;
      S_HALTED:    state_nxt = S_HALTED;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode from state and IR only, never from instr_data.
  always_comb begin
    instr_addr       = pc;
    rf_read_address1 = 3'd0;
    rf_read_address2 = 3'd0;
    rf_write_address = 3'd0;
    rf_write_enable  = 1'b0;
    rf_write_data    = 8'd0;
    alu_op           = 3'd0;
    busy             = 1'b0;
    halted           = 1'b0;
    case (state)
      S_FETCH: busy = 1'b1;
      S_DECODE: begin
        busy             = 1'b1;
        rf_read_address1 = rs1;
        rf_read_address2 = rs2;
      end
      S_EXECUTE: begin
        busy             = 1'b1;
        rf_read_address1 = rs1;
        rf_read_address2 = rs2;
        if (uses_alu) alu_op = 3'(opcode - OP_ADD);
      end
      S_WRITEBACK: begin
        busy             = 1'b1;
        rf_read_address1 = rs1;
        rf_read_address2 = rs2;
        rf_write_enable  = writes_rf;
        rf_write_address = rd;
        rf_write_data    = (opcode == OP_LDI) ? imm8 : result_q;
      end
      S_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

  assign illegal = illegal_q;

endmodule
